// File: rtl/readout_pkg.sv
// Shared definitions for the readout path: pixel width, serializer states, sizing helper.
package readout_pkg;

    localparam int unsigned PIXEL_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLoad
    } ser_state_t;

    // Bits needed to index 0..n-1; never less than 1 so a degenerate count still yields a
    // legal vector width.
    function automatic int unsigned ceil_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pixel_line_serializer.sv
// Serializes 8-bit pixels MSB-first into a contiguous bitstream for the downstream line
// shift register, strobes load after the last bit of a line and aborts the line on starvation.
module pixel_line_serializer
    import readout_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE = 1024,
    parameter int unsigned LCNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              shift_in,
    output logic              load,
    output logic              busy,
    output logic              underrun,
    output logic [LCNT_W-1:0] line_count
);

    localparam int unsigned PIX_W = ceil_log2(IMAGE_SIZE);
    localparam int unsigned BIT_W = ceil_log2(PIXEL_BITS);

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(PIXEL_BITS - 1);

    ser_state_t                state_q, state_d;
    logic [PIXEL_BITS-1:0]     hold_q, hold_d;
    logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
    logic [PIX_W-1:0]          pix_idx_q, pix_idx_d;
    logic [LCNT_W-1:0]         line_count_q, line_count_d;
    logic                      shift_in_q, shift_in_d;
    logic                      load_q, load_d;
    logic                      underrun_q, underrun_d;
    // Keeps pix_ready low while reset is held and for the release cycle.
    logic                      ready_en_q;

    // Next-state, datapath and handshake decode.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        bit_idx_d    = bit_idx_q;
        pix_idx_d    = pix_idx_q;
        line_count_d = line_count_q;
        underrun_d   = 1'b0;
        pix_ready    = 1'b0;

        unique case (state_q)
            StIdle: begin
                pix_ready = ready_en_q;
                if (ready_en_q && pix_valid) begin
                    hold_d    = pix_data;
                    bit_idx_d = TOP_BIT;
                    pix_idx_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (bit_idx_q != '0) begin
                    hold_d    = {hold_q[PIXEL_BITS-2:0], 1'b0};
                    bit_idx_d = bit_idx_q - BIT_W'(1);
                end else if (pix_idx_q == LAST_PIX) begin
                    state_d = StLoad;
                end else begin
                    // Next pixel must arrive exactly now: the downstream register never stalls.
                    pix_ready = 1'b1;
                    if (pix_valid) begin
                        hold_d    = pix_data;
                        bit_idx_d = TOP_BIT;
                        pix_idx_d = pix_idx_q + PIX_W'(1);
                    end else begin
                        state_d    = StIdle;
                        underrun_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                line_count_d = line_count_q + LCNT_W'(1);
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they align with the state they describe.
        shift_in_d = (state_d == StShift) ? hold_d[PIXEL_BITS-1] : 1'b0;
        load_d     = (state_d == StLoad);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            bit_idx_q    <= '0;
            pix_idx_q    <= '0;
            line_count_q <= '0;
            shift_in_q   <= 1'b0;
            load_q       <= 1'b0;
            underrun_q   <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            bit_idx_q    <= bit_idx_d;
            pix_idx_q    <= pix_idx_d;
            line_count_q <= line_count_d;
            shift_in_q   <= shift_in_d;
            load_q       <= load_d;
            underrun_q   <= underrun_d;
            ready_en_q   <= 1'b1;
        end
    end

    assign shift_in   = shift_in_q;
    assign load       = load_q;
    assign underrun   = underrun_q;
    assign line_count = line_count_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_pixel_line_serializer.sv
// Randomized bench for pixel_line_serializer with a timeline-based reference model and a
// behavioural downstream shift register.
module tb_pixel_line_serializer;

    localparam int N  = 4;
    localparam int LW = 3;
    localparam int LINE_BITS = 8 * N;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    pix_data = 8'h00;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic          shift_in;
    logic          load;
    logic          busy;
    logic          underrun;
    logic [LW-1:0] line_count;

    always #5 clk = ~clk;

    pixel_line_serializer #(
        .IMAGE_SIZE(N),
        .LCNT_W    (LW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .shift_in  (shift_in),
        .load      (load),
        .busy      (busy),
        .underrun  (underrun),
        .line_count(line_count)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int load_cycles[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream line register: shifts every clock, parallel output captured on load.
    logic [31:0] sr, data_out;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr       <= '0;
            data_out <= '0;
        end else begin
            if (load) data_out <= sr;
            sr <= {sr[30:0], shift_in};
        end
    end

    // Reference model: line timeline t = cycles since the first pixel was accepted.
    logic [7:0]  m_pix[N];
    bit          m_active, m_uflag, m_rdy_en;
    int          m_t, m_lc;
    logic [31:0] m_dw;

    function automatic logic e_ready();
        if (!m_rdy_en) return 1'b0;
        if (!m_active) return 1'b1;
        return (m_t < LINE_BITS) && (m_t % 8 == 7) && (m_t / 8 < N - 1);
    endfunction

    function automatic logic e_shift();
        logic [7:0] p;
        if (m_active && m_t < LINE_BITS) begin
            p = m_pix[m_t / 8];
            return p[7 - m_t % 8];
        end
        return 1'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_uflag  <= 1'b0;
            m_rdy_en <= 1'b0;
            m_t      <= 0;
            m_lc     <= 0;
            m_dw     <= '0;
        end else begin
            m_rdy_en <= 1'b1;
            m_uflag  <= 1'b0;
            if (!m_active) begin
                if (e_ready() && pix_valid) begin
                    m_pix[0] <= pix_data;
                    m_active <= 1'b1;
                    m_t      <= 0;
                end
            end else if (m_t == LINE_BITS) begin
                m_active <= 1'b0;
                m_lc     <= m_lc + 1;
                m_dw     <= {m_pix[0], m_pix[1], m_pix[2], m_pix[3]};
            end else if (e_ready()) begin
                if (pix_valid) begin
                    m_pix[m_t / 8 + 1] <= pix_data;
                    m_t <= m_t + 1;
                end else begin
                    m_active <= 1'b0;
                    m_uflag  <= 1'b1;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("pix_ready", 32'(pix_ready), 32'(e_ready()));
        chk("shift_in", 32'(shift_in), 32'(e_shift()));
        chk("load", 32'(load), 32'(m_active && m_t == LINE_BITS));
        chk("busy", 32'(busy), 32'(m_active));
        chk("underrun", 32'(underrun), 32'(m_uflag));
        chk("line_count", 32'(line_count), 32'(m_lc % (1 << LW)));
        chk("data_out", data_out, m_dw);
        if (load) load_cycles.push_back(cyc);
    end

    // Offer npix pixels of word; while pix_ready is low drive noise on pix_data/pix_valid.
    task automatic send_line(input logic [31:0] word, input int npix, input bit hold_valid);
        for (int i = 0; i < npix; i++) begin
            int guard;
            bit done;
            guard = 0;
            done  = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (pix_ready) begin
                    pix_valid = 1'b1;
                    pix_data  = word[31 - 8 * i -: 8];
                    @(posedge clk);
                    done = 1'b1;
                end else begin
                    pix_valid = hold_valid ? 1'b1 : 1'($urandom_range(0, 1));
                    pix_data  = 8'($urandom);
                    guard++;
                    if (guard > 100) begin
                        chk("handshake_timeout", 32'd1, 32'd0);
                        done = 1'b1;
                    end
                end
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("idle_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        int          np;

        // Reset held: outputs all zero while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_valid = 1'($urandom_range(0, 1));
            pix_data  = 8'($urandom);
        end
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_shift_in", 32'(shift_in), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_line_count", 32'(line_count), 32'd0);
        pix_valid = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(pix_ready), 32'd1);
        chk("post_rst_line_count", 32'(line_count), 32'd0);

        // Single line.
        send_line(32'hA53CFF00, 4, 1'b1);
        wait_idle();
        chk("line1_word", data_out, 32'hA53CFF00);
        chk("line1_count", 32'(line_count), 32'd1);

        // Underrun after pixel 1, then a clean line.
        send_line(32'h11223344, 2, 1'b0);
        wait_idle();
        chk("underrun_count", 32'(line_count), 32'd1);
        chk("underrun_no_load", data_out, 32'hA53CFF00);
        send_line(32'h01020304, 4, 1'b0);
        wait_idle();
        chk("recover_word", data_out, 32'h01020304);
        chk("recover_count", 32'(line_count), 32'd2);

        // Back-to-back lines.
        load_cycles.delete();
        send_line(32'h10203040, 4, 1'b1);
        send_line(32'h55AA55AA, 4, 1'b1);
        send_line(32'h89ABCDEF, 4, 1'b1);
        wait_idle();
        chk("b2b_loads", 32'(load_cycles.size()), 32'd3);
        if (load_cycles.size() == 3) begin
            chk("b2b_gap0", 32'(load_cycles[1] - load_cycles[0]), 32'd34);
            chk("b2b_gap1", 32'(load_cycles[2] - load_cycles[1]), 32'd34);
        end
        chk("b2b_word", data_out, 32'h89ABCDEF);
        chk("b2b_count", 32'(line_count), 32'd5);

        // Noise on pix_data/pix_valid while not ready must be ignored.
        send_line(32'hDEADBEEF, 4, 1'b0);
        wait_idle();
        chk("holdoff_word", data_out, 32'hDEADBEEF);

        // Reset asserted mid-line at cycle 10 of the line.
        send_line(32'hCAFEF00D, 2, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_shift_in", 32'(shift_in), 32'd0);
        chk("midrst_load", 32'(load), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_line_count", 32'(line_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        send_line(32'h0F1E2D3C, 4, 1'b0);
        wait_idle();
        chk("midrst_word", data_out, 32'h0F1E2D3C);
        chk("midrst_count", 32'(line_count), 32'd1);

        // Random lines with occasional starvation; the 3-bit counter wraps along the way.
        for (int k = 0; k < 14; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w  = $urandom;
            np = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : N;
            send_line(w, np, 1'($urandom_range(0, 1)));
            wait_idle();
            if (np == N) chk("rand_word", data_out, w);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_line_serializer.md
# pixel_line_serializer

Upstream feeder for the parallel line `shift_register`. It accepts 8-bit pixels over a valid/ready handshake and emits them as a contiguous MSB-first bitstream on `shift_in`, one bit per clock. After the last bit of a line it pulses `load` so the downstream register presents the whole line on its parallel output. It detects pixel starvation mid-line, because the downstream register shifts on every clock and has no enable.

## Interface
Parameters:
- `IMAGE_SIZE`, default 1024: pixels per line. Downstream `WIDTH` must equal `IMAGE_SIZE*8`.
- `LCNT_W`, default 16: width of the line counter.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pix_data` in 8: pixel value.
- `pix_valid` in 1: `pix_data` is valid.
- `pix_ready` out 1: pixel accepted on a clock edge where `pix_valid && pix_ready`.
- `shift_in` out 1: registered serial bit to the downstream register.
- `load` out 1: registered one-cycle line-load strobe to the downstream register.
- `busy` out 1: high in SHIFT or LOAD.
- `underrun` out 1: one-cycle pulse when a line is aborted for lack of a pixel.
- `line_count` out `LCNT_W`: count of completed lines; wraps modulo 2^`LCNT_W`.

## Operation
State machine: IDLE → SHIFT → LOAD → IDLE.

- **Datapath:** 8-bit holding register `hold`, bit index `bit_idx` (7 down to 0), pixel index `pix_idx` (0 to `IMAGE_SIZE`-1). `shift_in` equals `hold[7]` while in SHIFT; otherwise `shift_in` is 0.
- **IDLE:**
  - `pix_ready`=1.
  - On a handshake: `hold`←`pix_data`, `bit_idx`←7, `pix_idx`←0, go to SHIFT.
- **SHIFT:** each cycle, `hold` shifts left one bit and `bit_idx` decrements.
  - `pix_ready`=1 only when `bit_idx`==0 and `pix_idx`<`IMAGE_SIZE`-1.
  - **Handshake at that edge:** `hold`←`pix_data`, `bit_idx`←7, `pix_idx`+1. The stream continues with no gap.
  - **No handshake at that edge:** pulse `underrun` on the next cycle, go to IDLE, no `load`, `line_count` unchanged.
  - **`bit_idx`==0 and `pix_idx`==`IMAGE_SIZE`-1:** go to LOAD.
- **LOAD:**
  - `load`=1 for exactly one cycle, with `shift_in`=0 and `pix_ready`=0.
  - `line_count`+1 at the exiting edge, then go to IDLE.
- **Abort recovery:** after an abort, the next line simply restarts at pixel 0. `IMAGE_SIZE*8` contiguous bits fully overwrite the downstream register, so stale bits never reach a `load`.
- **Ignored input:** `pix_data` and `pix_valid` are ignored whenever `pix_ready`=0.

## Timing
- **Reset values:** `reset_n` low asynchronously forces state=IDLE, `shift_in`=0, `load`=0, `underrun`=0, `busy`=0, `line_count`=0, and `hold`, `bit_idx`, `pix_idx` to 0. `pix_ready` becomes 1 the first cycle after release.
- **Bit timing (first pixel accepted at edge E0):**
  - Bit 7 of pixel 0 is presented on `shift_in` in cycle E0..E1.
  - Bit k of pixel p is presented in cycle E(8p+7-k)..E(8p+8-k).
  - The downstream register samples each bit at the closing edge.
- **Load timing:** `load` is high in cycle E(8N)..E(8N+1), where N=`IMAGE_SIZE`. `line_count` is updated at E(8N+1).
- **Throughput:** minimum line period 8N+2 cycles (1 IDLE accept cycle, 8N SHIFT, 1 LOAD).
- **Underrun timing:** `underrun` is high in the cycle after the missed edge. `busy` falls in that same cycle.
- **Reset mid-line:** outputs clear immediately; no partial `load` is ever issued.
- **Line counter wrap:** `line_count` wraps 2^`LCNT_W`-1 → 0 without any flag.

## Structure
- Shared package `readout_pkg`:
  - `PIXEL_BITS`=8.
  - State enum `ser_state_t` {IDLE, SHIFT, LOAD}.
  - `ceil_log2` helper function used to size `pix_idx`.
- Single flat module; no sub-module is warranted.

## Test plan
All scenarios use `IMAGE_SIZE`=4, driving the real downstream `shift_register` (`WIDTH`=32).

- **Reset:** hold `reset_n` low, toggle inputs → all outputs 0. After release, `pix_ready`=1 and `line_count`=0.
- **Single line:** pixels A5, 3C, FF, 00 with `pix_valid` held high →
  - `shift_in` = 10100101 00111100 11111111 00000000 over 32 cycles;
  - `load` high in cycle 32;
  - downstream `data_out`=32'hA53CFF00;
  - `line_count`=1.
- **Underrun:** drop `pix_valid` after pixel 1 →
  - `underrun` pulses at cycle 17;
  - no `load`;
  - `line_count` unchanged;
  - next full line 01 02 03 04 loads 32'h01020304.
- **Back-to-back:** 3 lines with `pix_valid` always high →
  - `load` pulses exactly 34 cycles apart;
  - `line_count`=3;
  - each loaded word matches its line.
- **Handshake hold-off:** change `pix_data` while `pix_ready`=0 mid-pixel → value is ignored; the serialized bits match only the accepted values.
- **Reset mid-line:** assert `reset_n` low at cycle 10 →
  - `shift_in`, `load` and `busy` go to 0 immediately;
  - a subsequent line loads correctly;
  - `line_count`=1.
